// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the MEM-stage exception controller: ExcCodes, CP0 addresses,
// Status/Cause bit positions, exception-flag indices, FSM encodings and commit record.
// Latency: n/a (declarations only). Backpressure: n/a.
package exc_ctrl_pkg;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT = 5'h00;
  localparam logic [4:0] EXC_SYS = 5'h08;
  localparam logic [4:0] EXC_RI  = 5'h0A;
  localparam logic [4:0] EXC_OV  = 5'h0C;
  localparam logic [4:0] EXC_TR  = 5'h0D;

  // CP0 register addresses
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // Status / Cause bit positions
  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int IM_LO  = 8;
  localparam int IM_HI  = 15;

  // mem_excflags_i bit indices
  localparam int FLG_SYS  = 0;
  localparam int FLG_RI   = 1;
  localparam int FLG_TR   = 2;
  localparam int FLG_OV   = 3;
  localparam int FLG_ERET = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_BLANK = 2'd2
  } exc_state_t;

  // Everything latched at detection and replayed during the FLUSH cycle
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [4:0]  code;
    logic        bd;
    logic        eret;
  } commit_t;

  // A delay-slot instruction restarts at its branch, one word earlier
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic dslot);
    return dslot ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Multi-flop synchroniser for asynchronous level-sensitive interrupt lines.
// Latency: STAGES clk cycles from input to output.
// Backpressure: none; samples every cycle.
module exc_ctrl_int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // Shift chain; stage 0 takes the raw lines, the last stage is the output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt controller: arbitrates events, issues flush + CP0 update.
// Latency: event seen in cycle N -> one-cycle commit pulse in N+1, bubble cycle N+2.
// Backpressure: none; events arriving during FLUSH/BLANK are dropped. Optional EXC_STATS_EN adds exc_count_o.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_raw_i,
  input  logic        timer_int_i,
  output logic [5:0]  int_o,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_excflags_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_dslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        cp0_exc_we_o,
  output logic        cp0_eret_o,
  output logic [31:0] cp0_epc_o,
  output logic [4:0]  cp0_exccode_o,
  output logic        cp0_bd_o
`ifdef EXC_STATS_EN
  ,
  output logic [31:0] exc_count_o
`endif
);

  logic [5:0]  int_sync;
  logic [31:0] eff_status, eff_cause, eff_epc;
  logic [4:0]  flags;
  logic        int_pend, evt;
  commit_t     commit_d, commit_q;
  exc_state_t  state_q, state_d;
  logic        in_flush;
  logic        unused_bits;

  exc_ctrl_int_sync #(.WIDTH(6), .STAGES(SYNC_STAGES)) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d_i (int_raw_i),
    .q_o (int_sync)
  );

  // Timer interrupt is already in this clock domain, so it bypasses the synchroniser
  assign int_o = {int_sync[5] | timer_int_i, int_sync[4:0]};

  // Forward a WB-stage CP0 write; on Cause only the software-writable bits are taken
  always_comb begin
    eff_status = cp0_status_i;
    eff_cause  = cp0_cause_i;
    eff_epc    = cp0_epc_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_STATUS) eff_status = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_EPC)    eff_epc    = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_CAUSE) begin
      eff_cause[9:8] = wb_cp0_data_i[9:8];
      eff_cause[22]  = wb_cp0_data_i[22];
      eff_cause[23]  = wb_cp0_data_i[23];
    end
  end

  assign unused_bits = ^{eff_status[31:16], eff_status[7:2], eff_cause[31:16], eff_cause[7:0]};

  assign int_pend = eff_status[ST_IE] & ~eff_status[ST_EXL] & mem_valid_i &
                    (|(eff_cause[IM_HI:IM_LO] & eff_status[IM_HI:IM_LO]));
  assign flags    = mem_valid_i ? mem_excflags_i : 5'b0;

  // Priority select of the winning event and the values it would commit
  always_comb begin
    evt           = 1'b1;
    commit_d.pc   = EXC_VECTOR;
    commit_d.epc  = epc_of(mem_pc_i, mem_in_dslot_i);
    commit_d.bd   = mem_in_dslot_i;
    commit_d.eret = 1'b0;
    commit_d.code = EXC_INT;
    if (int_pend) begin
      commit_d.code = EXC_INT;
    end else if (flags[FLG_SYS]) begin
      commit_d.code = EXC_SYS;
    end else if (flags[FLG_RI]) begin
      commit_d.code = EXC_RI;
    end else if (flags[FLG_TR]) begin
      commit_d.code = EXC_TR;
    end else if (flags[FLG_OV]) begin
      commit_d.code = EXC_OV;
    end else if (flags[FLG_ERET]) begin
      commit_d.pc   = eff_epc;
      commit_d.epc  = 32'h0;
      commit_d.bd   = 1'b0;
      commit_d.eret = 1'b1;
    end else begin
      evt = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state: only IDLE accepts events; FLUSH and BLANK always advance
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = evt ? S_FLUSH : S_IDLE;
      S_FLUSH: state_d = S_BLANK;
      S_BLANK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the commit record on the accepting IDLE cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          commit_q <= '0;
    else if (state_q == S_IDLE && evt) commit_q <= commit_d;
  end

  // Outputs: driven only in FLUSH, so an async reset kills them immediately
  always_comb begin
    in_flush      = (state_q == S_FLUSH);
    flush_o       = in_flush;
    new_pc_o      = in_flush ? commit_q.pc : 32'h0;
    cp0_eret_o    = in_flush & commit_q.eret;
    cp0_exc_we_o  = in_flush & ~commit_q.eret;
    cp0_epc_o     = (in_flush & ~commit_q.eret) ? commit_q.epc  : 32'h0;
    cp0_exccode_o = (in_flush & ~commit_q.eret) ? commit_q.code : 5'h0;
    cp0_bd_o      = in_flush & ~commit_q.eret & commit_q.bd;
  end

`ifdef EXC_STATS_EN
  // Saturating count of accepted events (FLUSH entries)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      exc_count_o <= 32'h0;
    else if (state_q == S_IDLE && evt && exc_count_o != 32'hFFFF_FFFF)
      exc_count_o <= exc_count_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: interrupt sync, forwarding, priority, FSM timing, reset.
// Latency: checks are taken 1ns after each rising edge.
// Backpressure: n/a.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_raw_i;
  logic        timer_int_i;
  logic [5:0]  int_o;
  logic        mem_valid_i;
  logic [4:0]  mem_excflags_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_dslot_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        cp0_exc_we_o, cp0_eret_o;
  logic [31:0] cp0_epc_o;
  logic [4:0]  cp0_exccode_o;
  logic        cp0_bd_o;
`ifdef EXC_STATS_EN
  logic [31:0] exc_count_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .int_raw_i      (int_raw_i),
    .timer_int_i    (timer_int_i),
    .int_o          (int_o),
    .mem_valid_i    (mem_valid_i),
    .mem_excflags_i (mem_excflags_i),
    .mem_pc_i       (mem_pc_i),
    .mem_in_dslot_i (mem_in_dslot_i),
    .cp0_status_i   (cp0_status_i),
    .cp0_cause_i    (cp0_cause_i),
    .cp0_epc_i      (cp0_epc_i),
    .wb_cp0_we_i    (wb_cp0_we_i),
    .wb_cp0_waddr_i (wb_cp0_waddr_i),
    .wb_cp0_data_i  (wb_cp0_data_i),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .cp0_exc_we_o   (cp0_exc_we_o),
    .cp0_eret_o     (cp0_eret_o),
    .cp0_epc_o      (cp0_epc_o),
    .cp0_exccode_o  (cp0_exccode_o),
    .cp0_bd_o       (cp0_bd_o)
`ifdef EXC_STATS_EN
    ,
    .exc_count_o    (exc_count_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    mem_valid_i    = 1'b0;
    mem_excflags_i = 5'b0;
    mem_pc_i       = 32'h0;
    mem_in_dslot_i = 1'b0;
    cp0_status_i   = 32'h0;
    cp0_cause_i    = 32'h0;
    cp0_epc_i      = 32'h0;
    wb_cp0_we_i    = 1'b0;
    wb_cp0_waddr_i = 5'd0;
    wb_cp0_data_i  = 32'h0;
  endtask

  // Drop inputs, then walk FLUSH -> BLANK -> IDLE
  task automatic drain();
    clear_in();
    step();
    step();
  endtask

  initial begin
    rst         = 1'b0;
    int_raw_i   = 6'b0;
    timer_int_i = 1'b0;
    clear_in();
    #2;
    check("rst_flush",   {31'b0, flush_o}, 32'h0);
    check("rst_new_pc",  new_pc_o, 32'h0);
    check("rst_we_eret", {30'b0, cp0_exc_we_o, cp0_eret_o}, 32'h0);
    check("rst_epc",     cp0_epc_o, 32'h0);
    check("rst_code_bd", {26'b0, cp0_exccode_o, cp0_bd_o}, 32'h0);
    check("rst_int_o",   {26'b0, int_o}, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    step();

    // Interrupt line 2 through the 2-flop synchroniser
    int_raw_i = 6'b000100;
    step();
    check("sync_1clk", {26'b0, int_o}, 32'h0);
    step();
    check("sync_2clk", {26'b0, int_o}, 32'h4);
    timer_int_i = 1'b1;
    #1;
    check("timer_comb", {26'b0, int_o}, 32'h24);
    timer_int_i = 1'b0;

    // Interrupt once Cause.IP2 reflects it
    cp0_status_i = 32'h0000_0401;
    cp0_cause_i  = 32'h0000_0400;
    mem_valid_i  = 1'b1;
    #1;
    check("int_pre_edge", {31'b0, flush_o}, 32'h0);
    step();
    check("int_flush",  {31'b0, flush_o}, 32'h1);
    check("int_new_pc", new_pc_o, 32'h20);
    check("int_code",   {27'b0, cp0_exccode_o}, 32'h0);
    check("int_we",     {31'b0, cp0_exc_we_o}, 32'h1);
    clear_in();
    int_raw_i = 6'b0;
    step();
    check("int_blank", {31'b0, flush_o}, 32'h0);
    step();

    // Syscall, not in delay slot
    mem_pc_i = 32'h100; mem_excflags_i = 5'b00001; mem_valid_i = 1'b1;
    step();
    check("sys_flush", {31'b0, flush_o}, 32'h1);
    check("sys_epc",   cp0_epc_o, 32'h100);
    check("sys_bd",    {31'b0, cp0_bd_o}, 32'h0);
    check("sys_code",  {27'b0, cp0_exccode_o}, 32'h08);
    clear_in();
    step();
    check("sys_one_cycle", {31'b0, flush_o}, 32'h0);
    step();

    // Overflow + invalid in a delay slot: invalid wins
    mem_pc_i = 32'h204; mem_in_dslot_i = 1'b1; mem_excflags_i = 5'b01010; mem_valid_i = 1'b1;
    step();
    check("ri_code", {27'b0, cp0_exccode_o}, 32'h0A);
    check("ri_epc",  cp0_epc_o, 32'h200);
    check("ri_bd",   {31'b0, cp0_bd_o}, 32'h1);
    drain();

    // ERET with EPC forwarded from WB
    cp0_epc_i = 32'h40; wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h80;
    mem_excflags_i = 5'b10000; mem_valid_i = 1'b1;
    step();
    check("eret_flush",  {31'b0, flush_o}, 32'h1);
    check("eret_new_pc", new_pc_o, 32'h80);
    check("eret_pulse",  {31'b0, cp0_eret_o}, 32'h1);
    check("eret_we",     {31'b0, cp0_exc_we_o}, 32'h0);
    drain();

    // EXL masks the interrupt
    cp0_status_i = 32'h0000_0403; cp0_cause_i = 32'h0000_0400; mem_valid_i = 1'b1;
    step();
    check("exl_mask", {31'b0, flush_o}, 32'h0);
    clear_in();

    // Syscall presented during BLANK is dropped
    mem_pc_i = 32'h300; mem_excflags_i = 5'b00001; mem_valid_i = 1'b1;
    step();
    check("blank_first", {31'b0, flush_o}, 32'h1);
    clear_in();
    step();
    mem_excflags_i = 5'b00001; mem_valid_i = 1'b1;
    step();
    check("blank_drop", {31'b0, flush_o}, 32'h0);
    clear_in();
    step();
    check("blank_no_queue", {31'b0, flush_o}, 32'h0);

    // Flags ignored without a valid instruction
    mem_excflags_i = 5'b11111;
    step();
    check("invalid_slot", {31'b0, flush_o}, 32'h0);
    clear_in();

    // Interrupt beats syscall
    cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
    mem_excflags_i = 5'b00001; mem_valid_i = 1'b1; mem_pc_i = 32'h10;
    step();
    check("prio_int_code", {27'b0, cp0_exccode_o}, 32'h0);
    check("prio_int_we",   {31'b0, cp0_exc_we_o}, 32'h1);
    drain();

    // Trap beats overflow
    mem_excflags_i = 5'b01100; mem_valid_i = 1'b1;
    step();
    check("prio_trap", {27'b0, cp0_exccode_o}, 32'h0D);
    drain();

    // Forwarded software IP0 raises an interrupt
    cp0_status_i = 32'h0000_0101; wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd13;
    wb_cp0_data_i = 32'h0000_0100; mem_valid_i = 1'b1;
    step();
    check("fwd_sw_ip", {31'b0, flush_o}, 32'h1);
    drain();

    // Hardware IP bits are not taken from a WB Cause write
    cp0_status_i = 32'h0000_0401; wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd13;
    wb_cp0_data_i = 32'h0000_0400; mem_valid_i = 1'b1;
    step();
    check("fwd_hw_ip", {31'b0, flush_o}, 32'h0);
    clear_in();

    // Delay-slot EPC wraps below zero
    mem_excflags_i = 5'b00001; mem_in_dslot_i = 1'b1; mem_pc_i = 32'h0; mem_valid_i = 1'b1;
    step();
    check("epc_wrap", cp0_epc_o, 32'hFFFF_FFFC);
    drain();

    // Reset asserted in the middle of FLUSH
    mem_excflags_i = 5'b00001; mem_pc_i = 32'h500; mem_valid_i = 1'b1;
    step();
    check("rstmid_pre", {31'b0, flush_o}, 32'h1);
    clear_in();
    rst = 1'b0;
    #1;
    check("rstmid_flush",  {31'b0, flush_o}, 32'h0);
    check("rstmid_we",     {31'b0, cp0_exc_we_o}, 32'h0);
    check("rstmid_new_pc", new_pc_o, 32'h0);
    check("rstmid_epc",    cp0_epc_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("rstmid_idle", {31'b0, flush_o}, 32'h0);

    // Three back-to-back exceptions after reset
    for (int k = 0; k < 3; k++) begin
      mem_excflags_i = 5'b00001; mem_pc_i = 32'h600; mem_valid_i = 1'b1;
      step();
      check("post_rst_flush", {31'b0, flush_o}, 32'h1);
      drain();
    end
`ifdef EXC_STATS_EN
    check("stats_count", exc_count_o, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
